// File: rtl/grayscale_pipe.sv
// grayscale_pipe: two-stage RGB-to-grayscale converter between two FIFOs.
// Sustains one pixel per cycle with full back-pressure. MODE 0 takes the
// truncating 3-channel average; MODE 1 takes rounded BT.601-style luma.
// Optional macro GS_FRAME_CNT_EN adds a per-frame write counter driving
// frame_done; without it frame_done is tied low.
module grayscale_pipe #(
  parameter int CH_W         = 8,
  parameter int MODE         = 0,
  parameter int FRAME_PIXELS = 720*540
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_empty,
  input  logic [3*CH_W-1:0] in_dout,
  output logic              in_rd_en,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [CH_W-1:0]   out_din,
  output logic              frame_done
);

  localparam int SUM_W = (MODE == 1) ? CH_W + 8 : CH_W + 2;
  // One spare bit so the rounding offset can never wrap the sum.
  localparam int Q_W   = SUM_W + 1;

  if (MODE != 0 && MODE != 1) begin : g_mode_chk
    $error("grayscale_pipe: MODE must be 0 or 1");
  end
  if (FRAME_PIXELS < 1) begin : g_frame_chk
    $error("grayscale_pipe: FRAME_PIXELS must be at least 1");
  end

  // Channel sum (average mode) or weighted sum (luma mode), zero-extended.
  function automatic logic [SUM_W-1:0] pix_sum(input logic [3*CH_W-1:0] px);
    logic [SUM_W-1:0] r, g, b;
    r = SUM_W'(px[3*CH_W-1:2*CH_W]);
    g = SUM_W'(px[2*CH_W-1:CH_W]);
    b = SUM_W'(px[CH_W-1:0]);
    if (MODE == 1) return SUM_W'(77) * r + SUM_W'(150) * g + SUM_W'(29) * b;
    else           return r + g + b;
  endfunction

  // Luma: add half an LSB then drop the 8 fractional bits.
  function automatic logic [Q_W-1:0] round_shift(input logic [SUM_W-1:0] s);
    return ({1'b0, s} + Q_W'(128)) >> 8;
  endfunction

  // Clamp the quotient to the largest CH_W-bit sample.
  function automatic logic [CH_W-1:0] saturate(input logic [Q_W-1:0] q);
    if (q > Q_W'({CH_W{1'b1}})) return {CH_W{1'b1}};
    else                        return q[CH_W-1:0];
  endfunction

  // Stage-1 sum to stage-2 sample.
  function automatic logic [CH_W-1:0] sum_to_sample(input logic [SUM_W-1:0] s);
    if (MODE == 1) return saturate(round_shift(s));
    else           return saturate({1'b0, s} / Q_W'(3));
  endfunction

  logic [SUM_W-1:0] sum_p1_q, sum_p1_d;
  logic             vld_p1_q, vld_p1_d;
  logic [CH_W-1:0]  smp_p2_q, smp_p2_d;
  logic             vld_p2_q, vld_p2_d;
  logic             s2_ready, s1_ready, s1_adv;

  assign s2_ready  = ~vld_p2_q | ~out_full;
  assign s1_adv    = vld_p1_q & s2_ready;
  assign s1_ready  = ~vld_p1_q | s2_ready;
  assign in_rd_en  = ~reset & ~in_empty & s1_ready;
  assign out_wr_en = vld_p2_q & ~out_full;
  assign out_din   = smp_p2_q;

  // Next state of both stages: load on read/advance, drain on advance/write.
  always_comb begin
    sum_p1_d = sum_p1_q;
    vld_p1_d = vld_p1_q;
    smp_p2_d = smp_p2_q;
    vld_p2_d = vld_p2_q;
    // ---- input -> stage 1
    if (in_rd_en) begin
      sum_p1_d = pix_sum(in_dout);
      vld_p1_d = 1'b1;
    end else if (s1_adv) begin
      vld_p1_d = 1'b0;
    end
    // ---- stage 1 -> stage 2
    if (s1_adv) begin
      smp_p2_d = sum_to_sample(sum_p1_q);
      vld_p2_d = 1'b1;
    end else if (out_wr_en) begin
      vld_p2_d = 1'b0;
    end
  end

  // Pipeline registers; reset discards any in-flight pixels immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_p1_q <= '0;
      vld_p1_q <= 1'b0;
      smp_p2_q <= '0;
      vld_p2_q <= 1'b0;
    end else begin
      sum_p1_q <= sum_p1_d;
      vld_p1_q <= vld_p1_d;
      smp_p2_q <= smp_p2_d;
      vld_p2_q <= vld_p2_d;
    end
  end

`ifdef GS_FRAME_CNT_EN
  localparam int CNT_W = $clog2(FRAME_PIXELS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  assign wrap       = out_wr_en & (cnt_q == CNT_W'(FRAME_PIXELS - 1));
  assign frame_done = wrap;

  // Count writes; the frame's last write wraps the counter to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (wrap)           cnt_d = '0;
    else if (out_wr_en) cnt_d = cnt_q + CNT_W'(1);
  end

  // Frame counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_grayscale_pipe.sv
// tb_grayscale_pipe: scoreboard bench driving an average-mode and a luma-mode
// instance from one shared upstream/downstream FIFO model.
module tb_grayscale_pipe;

`ifdef GS_FRAME_CNT_EN
  localparam int FP    = 4;
  localparam bit FR_EN = 1'b1;
`else
  localparam int FP    = 720*540;
  localparam bit FR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_empty = 1'b1;
  logic [23:0] in_dout = '0;
  logic        out_full = 1'b0;
  logic        rd0, rd1, wr0, wr1, fd0, fd1;
  logic [7:0]  dout0, dout1;

  grayscale_pipe #(.CH_W(8), .MODE(0), .FRAME_PIXELS(FP)) u0 (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd0), .out_full(out_full), .out_wr_en(wr0), .out_din(dout0),
    .frame_done(fd0));

  grayscale_pipe #(.CH_W(8), .MODE(1), .FRAME_PIXELS(FP)) u1 (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(rd1), .out_full(out_full), .out_wr_en(wr1), .out_din(dout1),
    .frame_done(fd1));

  always #5 clock = ~clock;

  typedef struct { int avg; int luma; int rc; } exp_t;

  exp_t        expq[$];
  logic [23:0] srcq[$];
  int cmp = 0, errs = 0;
  int cyc = 0, nrd = 0, nwr = 0, wcnt_fr = 0;
  bit lat_chk = 1'b0, full_v = 1'b0, gap_v = 1'b0;
  bit last_rd, last_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push_px(input int r, input int g, input int b);
    srcq.push_back({r[7:0], g[7:0], b[7:0]});
  endtask

  // One cycle: drive inputs, sample mid-cycle, score, advance past the edge.
  task automatic tick();
    exp_t e;
    int r, g, b, l;
    bit efd;
    in_empty = (srcq.size() == 0) || gap_v;
    in_dout  = (srcq.size() != 0) ? srcq[0] : 24'h0;
    out_full = full_v;
    #2;
    last_rd = rd0;
    last_wr = wr0;
    check("rd_match", rd1, rd0);
    check("wr_match", wr1, wr0);
    if (in_empty) check("rd_when_empty", rd0, 0);
    if (wr0) begin
      cmp++;
      assert (expq.size() != 0) else begin
        errs++;
        $error("FAIL spurious_write: observed=write expected=no write");
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("avg_out", dout0, e.avg);
        check("luma_out", dout1, e.luma);
        if (lat_chk) check("latency", cyc - e.rc, 2);
      end
      efd = FR_EN && (((wcnt_fr + 1) % FP) == 0);
      check("frame_done0", fd0, efd);
      check("frame_done1", fd1, efd);
      wcnt_fr++;
      nwr++;
    end else begin
      check("frame_idle", fd0 | fd1, 0);
    end
    if (rd0) begin
      r = srcq[0][23:16]; g = srcq[0][15:8]; b = srcq[0][7:0];
      l = (77*r + 150*g + 29*b + 128) >> 8;
      if (l > 255) l = 255;
      e.avg = (r + g + b) / 3;
      e.luma = l;
      e.rc = cyc;
      expq.push_back(e);
      void'(srcq.pop_front());
      nrd++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Run until source and scoreboard are empty, bounded.
  task automatic drain();
    int guard = 0;
    while ((srcq.size() != 0 || expq.size() != 0) && guard < 400) begin
      tick();
      guard++;
    end
    check("drain_done", (srcq.size() == 0 && expq.size() == 0), 1);
  endtask

  initial begin
    int rd_bp, wr_base;
    @(posedge clock);
    #1;
    // Reset state
    for (int i = 0; i < 2; i++) begin
      check("rst_rd", rd0, 0);
      check("rst_wr", wr0 | wr1, 0);
      check("rst_dout0", dout0, 0);
      check("rst_dout1", dout1, 0);
      check("rst_fd", fd0 | fd1, 0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;

    // Directed averages and lumas, latency checked
    lat_chk = 1'b1;
    push_px(255, 255, 255);
    push_px(10, 20, 31);
    drain();
    push_px(255, 0, 0);
    push_px(0, 255, 0);
    push_px(0, 0, 255);
    push_px(255, 255, 255);
    push_px(0, 0, 0);
    push_px(1, 1, 0);
    drain();

    // Throughput: 16 back-to-back pixels
    for (int i = 0; i < 16; i++)
      push_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i < 16) check("tp_rd", last_rd, 1);
      if (i >= 2) check("tp_wr", last_wr, 1);
    end
    drain();
    lat_chk = 1'b0;

    // Back-pressure from an empty pipe: two reads fill S1/S2, then stall
    wr_base = nwr;
    full_v = 1'b1;
    for (int i = 0; i < 32; i++)
      push_px($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    rd_bp = nrd;
    for (int i = 0; i < 5; i++) tick();
    check("bp_reads", nrd - rd_bp, 2);
    check("bp_rd_low", last_rd, 0);
    check("bp_no_wr", nwr - wr_base, 0);
    full_v = 1'b0;
    tick();
    check("bp_resume_wr", last_wr, 1);
    for (int i = 0; i < 300 && (srcq.size() != 0 || expq.size() != 0); i++) begin
      full_v = ($urandom_range(0, 2) == 0);
      gap_v  = ($urandom_range(0, 3) == 0);
      tick();
    end
    full_v = 1'b0;
    gap_v  = 1'b0;
    drain();
    check("bp_total_writes", nwr - wr_base, 32);

    // Reset with both stages valid
    full_v = 1'b1;
    push_px(100, 100, 100);
    push_px(50, 60, 70);
    push_px(1, 2, 3);
    push_px(4, 5, 6);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_wr", wr0 | wr1, 0);
    check("mid_rst_rd", rd0 | rd1, 0);
    check("mid_rst_dout", {dout1, dout0}, 0);
    tick();
    check("in_rst_rd", last_rd, 0);
    check("in_rst_wr", last_wr, 0);
    expq.delete();
    srcq.delete();
    wcnt_fr = 0;
    reset  = 1'b0;
    full_v = 1'b0;
    push_px(200, 10, 30);
    push_px(7, 8, 9);
    push_px(90, 180, 45);
    tick();
    check("post_rst_wr", last_wr, 0);
    lat_chk = 1'b1;
    drain();

    // Frame counting over 9 more pixels
    for (int i = 0; i < 9; i++) push_px(i * 20, 255 - i * 20, i * 7);
    drain();
    check("frame_writes", wcnt_fr, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
